// File: rtl/sdram_uart_pkg.sv
// Shared constants for the UART <-> SDRAM command path.
// Opcodes, decoder state encodings and timeout derivation.
package sdram_uart_pkg;

  localparam logic [7:0] CMD_WR = 8'h44;
  localparam logic [7:0] CMD_RD = 8'h55;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE       = 2'd0;
  localparam state_t ST_WR_COLLECT = 2'd1;
  localparam state_t ST_WR_REQ     = 2'd2;
  localparam state_t ST_RD_REQ     = 2'd3;

  localparam longint CLK_HZ     = 200_000_000;
  localparam longint BAUD       = 9600;
  localparam longint BYTE_BITS  = 10;
  localparam longint TMO_BYTES  = 4;

  // four byte-times of silence between payload bytes
  localparam int TIMEOUT_DEF =
    int'((CLK_HZ * BYTE_BITS * TMO_BYTES) / BAUD);

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_cmd_decode_if.sv
// Byte, FIFO and request handshake bundle of the command decoder.
// master = decoder side, slave = surrounding top / bench side.
interface uart_cmd_decode_if #(
  parameter int D_WIDTH = 8
);

  logic [D_WIDTH-1:0] rx_data;
  logic               rx_valid;
  logic               wfifo_full;
  logic               wfifo_wr_en;
  logic [D_WIDTH-1:0] wfifo_wr_data;
  logic               wfifo_flush;
  logic               wr_req;
  logic               wr_ack;
  logic               rd_req;
  logic               rd_ack;
  logic               err_cmd;
  logic               err_tmo;
  logic               err_ovf;

  modport master (
    input  rx_data, rx_valid, wfifo_full,
    input  wr_ack, rd_ack,
    output wfifo_wr_en, wfifo_wr_data, wfifo_flush,
    output wr_req, rd_req,
    output err_cmd, err_tmo, err_ovf
  );

  modport slave (
    output rx_data, rx_valid, wfifo_full,
    output wr_ack, rd_ack,
    input  wfifo_wr_en, wfifo_wr_data, wfifo_flush,
    input  wr_req, rd_req,
    input  err_cmd, err_tmo, err_ovf
  );

endinterface

// File: rtl/uart_byte_timeout.sv
// Saturating inter-byte counter with clear/enable.
// tc flags the cycle in which the limit is hit with no clear.
module uart_byte_timeout #(
  parameter int LIMIT = 833_333
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  import sdram_uart_pkg::*;

  localparam int W = cnt_w(LIMIT);
  localparam logic [W-1:0] TERM = W'(LIMIT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != TERM) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc = en && !clr && (cnt == TERM);

endmodule

// File: rtl/uart_cmd_decode.sv
// UART byte stream -> write FIFO pushes and SDRAM rd/wr requests.
// Truncated WRITE frames are dropped by timeout with a FIFO flush.
module uart_cmd_decode #(
  parameter int D_WIDTH     = 8,
  parameter int BURST_LEN   = 4,
  parameter logic [D_WIDTH-1:0] CMD_WR =
    D_WIDTH'(sdram_uart_pkg::CMD_WR),
  parameter logic [D_WIDTH-1:0] CMD_RD =
    D_WIDTH'(sdram_uart_pkg::CMD_RD),
  parameter int TIMEOUT_CYC = sdram_uart_pkg::TIMEOUT_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  uart_cmd_decode_if.master bus
);

  import sdram_uart_pkg::*;

  localparam int BW = $clog2(BURST_LEN + 1);
  localparam logic [BW-1:0] LAST = BW'(BURST_LEN - 1);

  state_t        state;
  logic [BW-1:0] byte_cnt;
  logic          tmo_clr;
  logic          tmo_en;
  logic          tmo_tc;

  // silence is only counted while a payload is outstanding
  assign tmo_en  = (state == ST_WR_COLLECT);
  assign tmo_clr = !tmo_en || bus.rx_valid;

  uart_byte_timeout #(
    .LIMIT (TIMEOUT_CYC)
  ) u_tmo (
    .clk (sys_clk),
    .rst (sys_rst),
    .clr (tmo_clr),
    .en  (tmo_en),
    .tc  (tmo_tc)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state             <= ST_IDLE;
      byte_cnt          <= '0;
      bus.wfifo_wr_en   <= 1'b0;
      bus.wfifo_wr_data <= '0;
      bus.wfifo_flush   <= 1'b0;
      bus.wr_req        <= 1'b0;
      bus.rd_req        <= 1'b0;
      bus.err_cmd       <= 1'b0;
      bus.err_tmo       <= 1'b0;
      bus.err_ovf       <= 1'b0;
    end else begin
      bus.wfifo_wr_en <= 1'b0;
      bus.wfifo_flush <= 1'b0;
      bus.err_cmd     <= 1'b0;
      bus.err_tmo     <= 1'b0;
      bus.err_ovf     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.rx_valid) begin
            if (bus.rx_data == CMD_WR) begin
              state    <= ST_WR_COLLECT;
              byte_cnt <= '0;
            end else if (bus.rx_data == CMD_RD) begin
              state      <= ST_RD_REQ;
              bus.rd_req <= 1'b1;
            end else begin
              bus.err_cmd <= 1'b1;
            end
          end
        end
        ST_WR_COLLECT: begin
          if (bus.rx_valid && !bus.wfifo_full) begin
            bus.wfifo_wr_en   <= 1'b1;
            bus.wfifo_wr_data <= bus.rx_data;
            byte_cnt          <= byte_cnt + BW'(1);
            if (byte_cnt == LAST) begin
              state      <= ST_WR_REQ;
              bus.wr_req <= 1'b1;
            end
          end else if (bus.rx_valid) begin
            bus.err_ovf     <= 1'b1;
            bus.wfifo_flush <= 1'b1;
            state           <= ST_IDLE;
          end else if (tmo_tc) begin
            bus.err_tmo     <= 1'b1;
            bus.wfifo_flush <= 1'b1;
            state           <= ST_IDLE;
          end
        end
        ST_WR_REQ: begin
          bus.err_cmd <= bus.rx_valid;
          if (bus.wr_ack) begin
            bus.wr_req <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        ST_RD_REQ: begin
          bus.err_cmd <= bus.rx_valid;
          if (bus.rd_ack) begin
            bus.rd_req <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_decode.sv
// Bench for uart_cmd_decode: vector table, directed corner
// sequences and random traffic against a frame-level model.
module tb_uart_cmd_decode;

  localparam int T = 40;
  localparam int B = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_cmd_decode_if #(.D_WIDTH(8)) bus ();

  uart_cmd_decode #(
    .D_WIDTH     (8),
    .BURST_LEN   (B),
    .CMD_WR      (8'h44),
    .CMD_RD      (8'h55),
    .TIMEOUT_CYC (T)
  ) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bus)
  );

  typedef struct packed {
    logic       wen;
    logic [7:0] wd;
    logic       fl;
    logic       wq;
    logic       rq;
    logic       ec;
    logic       et;
    logic       eo;
  } out_t;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       wk;
    logic       rk;
    out_t       exp;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // model: payload bytes still owed, silence length, open requests
  bit   m_col;
  int   m_rem;
  int   m_sil;
  bit   m_wq;
  bit   m_rq;
  out_t m_exp;

  function automatic out_t dut_out();
    out_t o;
    o.wen = bus.wfifo_wr_en;
    o.wd  = bus.wfifo_wr_data;
    o.fl  = bus.wfifo_flush;
    o.wq  = bus.wr_req;
    o.rq  = bus.rd_req;
    o.ec  = bus.err_cmd;
    o.et  = bus.err_tmo;
    o.eo  = bus.err_ovf;
    return o;
  endfunction

  function automatic vec_t vv(
    input logic v, input logic [7:0] d,
    input logic wk, input logic rk,
    input logic wen, input logic [7:0] wd,
    input logic wq, input logic rq, input logic ec);
    vec_t r;
    r.v = v; r.d = d; r.wk = wk; r.rk = rk;
    r.exp = '0;
    r.exp.wen = wen; r.exp.wd = wd;
    r.exp.wq = wq; r.exp.rq = rq; r.exp.ec = ec;
    return r;
  endfunction

  task automatic cmp(input string nm, input out_t got, input out_t exp);
    total++;
    if (got.wen !== exp.wen || (exp.wen && got.wd !== exp.wd) ||
        got.fl !== exp.fl || got.wq !== exp.wq || got.rq !== exp.rq ||
        got.ec !== exp.ec || got.et !== exp.et || got.eo !== exp.eo) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic model_reset();
    m_col = 0; m_rem = 0; m_sil = 0;
    m_wq = 0; m_rq = 0; m_exp = '0;
  endtask

  task automatic model_step();
    out_t e;
    e = '0;
    if (m_wq) begin
      e.ec = bus.rx_valid;
      if (bus.wr_ack) m_wq = 0;
    end else if (m_rq) begin
      e.ec = bus.rx_valid;
      if (bus.rd_ack) m_rq = 0;
    end else if (m_col) begin
      if (bus.rx_valid && !bus.wfifo_full) begin
        e.wen = 1; e.wd = bus.rx_data;
        m_sil = 0;
        m_rem--;
        if (m_rem == 0) begin m_col = 0; m_wq = 1; end
      end else if (bus.rx_valid) begin
        e.eo = 1; e.fl = 1; m_col = 0;
      end else begin
        m_sil++;
        if (m_sil == T) begin e.et = 1; e.fl = 1; m_col = 0; end
      end
    end else if (bus.rx_valid) begin
      if (bus.rx_data == 8'h44) begin
        m_col = 1; m_rem = B; m_sil = 0;
      end else if (bus.rx_data == 8'h55) begin
        m_rq = 1;
      end else begin
        e.ec = 1;
      end
    end
    e.wq = m_wq;
    e.rq = m_rq;
    m_exp = e;
  endtask

  task automatic tick(input string nm);
    @(posedge clk);
    model_step();
    #1;
    cmp(nm, dut_out(), m_exp);
  endtask

  task automatic send(input logic [7:0] d, input string nm);
    bus.rx_valid = 1'b1;
    bus.rx_data  = d;
    tick(nm);
    bus.rx_valid = 1'b0;
  endtask

  vec_t tbl[20];

  initial begin
    int n;
    int pushes;

    tbl[0]  = vv(1, 8'h44, 0, 0, 0, 8'h00, 0, 0, 0);
    tbl[1]  = vv(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);
    tbl[2]  = vv(1, 8'h3C, 0, 0, 1, 8'h3C, 0, 0, 0);
    tbl[3]  = vv(1, 8'hA1, 0, 0, 1, 8'hA1, 0, 0, 0);
    tbl[4]  = vv(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);
    tbl[5]  = vv(1, 8'h07, 0, 0, 1, 8'h07, 0, 0, 0);
    tbl[6]  = vv(1, 8'hFF, 0, 0, 1, 8'hFF, 1, 0, 0);
    tbl[7]  = vv(0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0);
    tbl[8]  = vv(0, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0);
    tbl[9]  = vv(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0);
    tbl[10] = vv(1, 8'h55, 0, 1, 0, 8'h00, 0, 1, 0);
    tbl[11] = vv(0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0);
    tbl[12] = vv(0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0);
    tbl[13] = vv(1, 8'h12, 0, 0, 0, 8'h00, 0, 0, 1);
    tbl[14] = vv(1, 8'h55, 0, 0, 0, 8'h00, 0, 1, 0);
    tbl[15] = vv(0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 0);
    tbl[16] = vv(1, 8'h44, 0, 0, 0, 8'h00, 0, 1, 1);
    tbl[17] = vv(0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 0);
    tbl[18] = vv(0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0);
    tbl[19] = vv(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);

    bus.rx_valid   = 1'b0;
    bus.rx_data    = 8'h00;
    bus.wfifo_full = 1'b0;
    bus.wr_ack     = 1'b0;
    bus.rd_ack     = 1'b0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    cmp("reset", dut_out(), '0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      bus.rx_valid = tbl[i].v;
      bus.rx_data  = tbl[i].d;
      bus.wr_ack   = tbl[i].wk;
      bus.rd_ack   = tbl[i].rk;
      tick($sformatf("vec%0d_model", i));
      cmp($sformatf("vec%0d", i), dut_out(), tbl[i].exp);
    end
    bus.rx_valid = 1'b0;
    bus.wr_ack   = 1'b0;
    bus.rd_ack   = 1'b0;

    // truncated frame: timeout counted from the 2nd payload byte
    send(8'h44, "tmo_op");
    send(8'h11, "tmo_b0");
    send(8'h22, "tmo_b1");
    n = 0;
    for (int k = 1; k <= T + 5; k++) begin
      tick("tmo_wait");
      if (bus.err_tmo) begin
        n = k;
        break;
      end
    end
    chk("tmo_latency", n, T);
    chk("tmo_flush", int'(bus.wfifo_flush), 1);
    bus.rd_ack = 1'b1;
    send(8'h55, "tmo_rd");
    chk("tmo_then_rd", int'(bus.rd_req), 1);
    tick("tmo_rd_done");
    bus.rd_ack = 1'b0;

    // FIFO full while collecting
    send(8'h44, "ovf_op");
    send(8'h5A, "ovf_b0");
    bus.wfifo_full = 1'b1;
    send(8'h6B, "ovf_b1");
    chk("ovf_err", int'(bus.err_ovf && bus.wfifo_flush), 1);
    chk("ovf_nopush", int'(bus.wfifo_wr_en), 0);
    bus.wfifo_full = 1'b0;
    bus.rd_ack = 1'b1;
    send(8'h55, "ovf_rd");
    chk("ovf_idle", int'(bus.rd_req), 1);
    tick("ovf_rd_done");
    bus.rd_ack = 1'b0;

    // reset mid-frame, then a clean frame
    send(8'h44, "rst_op");
    send(8'h01, "rst_b0");
    send(8'h02, "rst_b1");
    #2;
    rst = 1'b1;
    #1;
    cmp("rst_async", dut_out(), '0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    send(8'h44, "post_op");
    pushes = 0;
    for (int k = 0; k < B; k++) begin
      send(8'(8'hC0 + k), "post_byte");
      pushes += int'(bus.wfifo_wr_en);
    end
    chk("post_pushes", pushes, B);
    chk("post_wr_req", int'(bus.wr_req), 1);
    bus.wr_ack = 1'b1;
    tick("post_ack");
    bus.wr_ack = 1'b0;
    chk("post_wr_drop", int'(bus.wr_req), 0);

    // random traffic, alternating busy and sparse phases
    for (int i = 0; i < 3000; i++) begin
      int r;
      int pct;
      pct = ((i / 500) % 2 == 1) ? 2 : 30;
      r = $urandom_range(0, 9);
      bus.rx_valid   = ($urandom_range(0, 99) < pct);
      bus.rx_data    = (r < 3) ? 8'h44 : (r < 5) ? 8'h55
                                  : 8'($urandom);
      bus.wfifo_full = ($urandom_range(0, 9) == 0);
      bus.wr_ack     = ($urandom_range(0, 9) < 3);
      bus.rd_ack     = ($urandom_range(0, 9) < 3);
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
